// File: rtl/exec_resp_bfm.sv
// rtl/exec_resp_bfm.sv - PDP-8 execution-response BFM: stalls fetch/decode per instruction, tracks PC and counters
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp_pkg;
  typedef struct packed {
    logic                   op_jmp;
    logic                   op_jms;
    logic                   op_dca;
    logic                   op_isz;
    logic                   op_tad;
    logic                   op_and;
    logic [`DATA_WIDTH-1:0] mem_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic [21:0] code;
  } pdp_op7_opcode_s;

  localparam int HLT_BIT = 9;
  localparam int SKP_BIT = 7;
endpackage

module exec_resp_bfm
  import pdp_pkg::*;
#(
  parameter int MEM_CYCLES = 2,
  parameter int OP7_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [`ADDR_WIDTH-1:0] base_addr,
  input  pdp_mem_opcode_s        pdp_mem_opcode,
  input  pdp_op7_opcode_s        pdp_op7_opcode,
  output logic                   stall,
  output logic [`ADDR_WIDTH-1:0] PC_value,
  output logic [31:0]            instr_count,
  output logic [15:0]            err_count,
  output logic                   illegal_op,
  output logic                   halted
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_CLR, HALT} state_t;

  localparam logic [3:0] MEM_LAST = 4'(MEM_CYCLES - 1);
  localparam logic [3:0] OP7_LAST = 4'(OP7_CYCLES - 1);

  state_t                 state;
  logic [3:0]             cnt;
  logic                   base_loaded;
  pdp_mem_opcode_s        cap_mem;
  pdp_op7_opcode_s        cap_op7;
  logic [5:0]             mem_bits;
  logic                   present;
  logic                   legal;
  logic [`ADDR_WIDTH-1:0] next_pc;

  // Only the one-hot bits define an opcode; the operand address alone is not one.
  assign mem_bits = {pdp_mem_opcode.op_jmp, pdp_mem_opcode.op_jms, pdp_mem_opcode.op_dca,
                     pdp_mem_opcode.op_isz, pdp_mem_opcode.op_tad, pdp_mem_opcode.op_and};
  assign present  = (|mem_bits) || (|pdp_op7_opcode.code);
  assign legal    = $onehot({mem_bits, pdp_op7_opcode.code});

  always_comb begin
    next_pc = PC_value + `ADDR_WIDTH'(1);
    if (cap_mem.op_jmp)
      next_pc = cap_mem.mem_addr[`ADDR_WIDTH-1:0];
    else if (cap_mem.op_jms)
      next_pc = cap_mem.mem_addr[`ADDR_WIDTH-1:0] + `ADDR_WIDTH'(1);
    else if (cap_op7.code[SKP_BIT])
      next_pc = PC_value + `ADDR_WIDTH'(2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      stall       <= 1'b0;
      PC_value    <= '0;
      instr_count <= '0;
      err_count   <= '0;
      illegal_op  <= 1'b0;
      halted      <= 1'b0;
      cnt         <= '0;
      cap_mem     <= '0;
      cap_op7     <= '0;
      base_loaded <= 1'b0;
    end else begin
      illegal_op <= 1'b0;
      // The first edge after reset only seeds the PC; decoding starts on the next one.
      if (!base_loaded) begin
        PC_value    <= base_addr;
        base_loaded <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (present) begin
              if (legal) begin
                cap_mem <= pdp_mem_opcode;
                cap_op7 <= pdp_op7_opcode;
                cnt     <= (|mem_bits) ? MEM_LAST : OP7_LAST;
                stall   <= 1'b1;
                state   <= EXEC;
              end else begin
                illegal_op <= 1'b1;
                if (err_count != 16'hFFFF)
                  err_count <= err_count + 16'd1;
                state <= WAIT_CLR;
              end
            end
          end
          EXEC: begin
            if (cnt == 4'd0) begin
              instr_count <= instr_count + 32'd1;
              PC_value    <= next_pc;
              if (cap_op7.code[HLT_BIT]) begin
                halted <= 1'b1;
                state  <= HALT;
              end else begin
                stall <= 1'b0;
                state <= WAIT_CLR;
              end
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          WAIT_CLR: begin
            if (!present)
              state <= IDLE;
          end
          HALT: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exec_resp_bfm.sv
// tb/tb_exec_resp_bfm.sv - self-checking bench for exec_resp_bfm: vector table with scoreboard plus halt/reset sequences
module tb_exec_resp_bfm;
  import pdp_pkg::*;

  localparam logic [5:0] JMP  = 6'b100000;
  localparam logic [5:0] JMS  = 6'b010000;
  localparam logic [5:0] DCA  = 6'b001000;
  localparam logic [5:0] ISZ  = 6'b000100;
  localparam logic [5:0] TAD  = 6'b000010;
  localparam logic [5:0] ANDO = 6'b000001;

  typedef struct {
    pdp_mem_opcode_s mem;
    pdp_op7_opcode_s op7;
    logic [11:0]     pc;
    int              lat;
    bit              ill;
  } vec_t;

  typedef struct {
    logic [11:0] pc;
    int          lat;
    bit          ill;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            rst4_n;
  logic [11:0]     base_addr;
  pdp_mem_opcode_s mem_op;
  pdp_op7_opcode_s op7_op;

  logic        stall, illegal_op, halted;
  logic [11:0] pc;
  logic [31:0] instr_count;
  logic [15:0] err_count;

  logic        stall4, illegal_op4, halted4;
  logic [11:0] pc4;
  logic [31:0] instr_count4;
  logic [15:0] err_count4;

  int   compared = 0;
  int   mismatched = 0;
  int   exp_instr = 0;
  int   exp_err = 0;
  exp_t sbq[$];
  vec_t vecs[15];

  exec_resp_bfm dut (
    .clk(clk), .reset_n(reset_n), .base_addr(base_addr),
    .pdp_mem_opcode(mem_op), .pdp_op7_opcode(op7_op),
    .stall(stall), .PC_value(pc), .instr_count(instr_count),
    .err_count(err_count), .illegal_op(illegal_op), .halted(halted)
  );

  exec_resp_bfm #(.MEM_CYCLES(4)) dut4 (
    .clk(clk), .reset_n(rst4_n), .base_addr(base_addr),
    .pdp_mem_opcode(mem_op), .pdp_op7_opcode(op7_op),
    .stall(stall4), .PC_value(pc4), .instr_count(instr_count4),
    .err_count(err_count4), .illegal_op(illegal_op4), .halted(halted4)
  );

  always #5 clk = ~clk;

  function automatic pdp_mem_opcode_s mk_mem(input logic [5:0] ops, input logic [11:0] a);
    return pdp_mem_opcode_s'({ops, a});
  endfunction

  function automatic pdp_op7_opcode_s mk_op7(input int b);
    pdp_op7_opcode_s r;
    r.code    = '0;
    r.code[b] = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   sc = 0;
    int   ic = 0;
    @(negedge clk);
    mem_op = v.mem;
    op7_op = v.op7;
    sbq.push_back('{v.pc, v.lat, v.ill});
    // Opcode stays held for the whole window so any double execution would show up.
    repeat (20) begin
      @(negedge clk);
      if (stall) sc++;
      if (illegal_op) ic++;
    end
    mem_op = '0;
    op7_op = '0;
    repeat (2) @(negedge clk);
    e = sbq.pop_front();
    if (e.ill) begin
      if (exp_err != 16'hFFFF) exp_err++;
    end else begin
      exp_instr++;
    end
    check("pc", 32'(pc), 32'(e.pc));
    check("stall_cycles", 32'(sc), 32'(e.lat));
    check("illegal_pulses", 32'(ic), e.ill ? 32'd1 : 32'd0);
    check("instr_count", instr_count, 32'(exp_instr));
    check("err_count", 32'(err_count), 32'(exp_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'd0);
    check({tag, "_instr"}, instr_count, 32'd0);
    check({tag, "_err"}, 32'(err_count), 32'd0);
    check({tag, "_illegal"}, 32'(illegal_op), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  initial begin
    int sc;
    vecs[0]  = '{mk_mem(ANDO, 12'd1),      '0,          12'o201,  2, 1'b0};
    vecs[1]  = '{mk_mem(JMP, 12'd12),      '0,          12'd12,   2, 1'b0};
    vecs[2]  = '{mk_mem(JMS, 12'd10),      '0,          12'd11,   2, 1'b0};
    vecs[3]  = '{'0,                       mk_op7(7),   12'd13,   1, 1'b0};
    vecs[4]  = '{mk_mem(ANDO | TAD, 12'd0), '0,         12'd13,   0, 1'b1};
    vecs[5]  = '{mk_mem(ANDO, 12'd3),      mk_op7(0),   12'd13,   0, 1'b1};
    vecs[6]  = '{mk_mem(TAD, 12'd5),       '0,          12'd14,   2, 1'b0};
    vecs[7]  = '{mk_mem(DCA, 12'd5),       '0,          12'd15,   2, 1'b0};
    vecs[8]  = '{mk_mem(ISZ, 12'd5),       '0,          12'd16,   2, 1'b0};
    vecs[9]  = '{mk_mem(JMP, 12'o7777),    '0,          12'o7777, 2, 1'b0};
    vecs[10] = '{'0,                       mk_op7(0),   12'd0,    1, 1'b0};
    vecs[11] = '{mk_mem(JMP, 12'o7776),    '0,          12'o7776, 2, 1'b0};
    vecs[12] = '{'0,                       mk_op7(7),   12'd0,    1, 1'b0};
    vecs[13] = '{mk_mem(JMS, 12'o7777),    '0,          12'd0,    2, 1'b0};
    vecs[14] = '{'0,                       mk_op7(21),  12'd1,    1, 1'b0};

    reset_n   = 1'b0;
    rst4_n    = 1'b0;
    base_addr = 12'o200;
    mem_op    = '0;
    op7_op    = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    #1 check("pc_before_load", 32'(pc), 32'd0);
    @(negedge clk);
    check("pc_base_load", 32'(pc), 32'o200);
    repeat (2) @(negedge clk);
    check("pc_base_once", 32'(pc), 32'o200);

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // HLT from PC=1: PC advances once, then stall and halted stick while opcodes keep arriving.
    @(negedge clk);
    op7_op = mk_op7(9);
    @(negedge clk);
    op7_op = '0;
    mem_op = mk_mem(JMP, 12'd5);
    sc = 0;
    repeat (100) begin
      @(negedge clk);
      if (stall) sc++;
    end
    check("halt_stall_cycles", 32'(sc), 32'd100);
    check("halted", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc), 32'd2);
    check("halt_instr", instr_count, 32'(exp_instr + 1));

    // Abort a 4-cycle memory op mid-EXEC on the second instance.
    mem_op = '0;
    @(negedge clk);
    rst4_n = 1'b1;
    repeat (2) @(negedge clk);
    mem_op = mk_mem(ANDO, 12'd1);
    repeat (3) @(negedge clk);
    check("m4_stall_mid", 32'(stall4), 32'd1);
    #2 rst4_n = 1'b0;
    #1 check("m4_stall_async", 32'(stall4), 32'd0);
    mem_op = '0;
    @(negedge clk);
    rst4_n = 1'b1;
    repeat (8) @(negedge clk);
    check("m4_instr_after", instr_count4, 32'd0);
    check("m4_stall_after", 32'(stall4), 32'd0);
    check("m4_pc_after", 32'(pc4), 32'o200);

    check("halt_still_stalled", 32'(stall), 32'd1);
    check("halt_pc_kept", 32'(pc), 32'd2);

    #2 reset_n = 1'b0;
    #1 check_reset_outputs("halt_rst");
    base_addr = 12'o300;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("pc_reload", 32'(pc), 32'o300);
    exp_instr = 0;
    exp_err   = 0;
    run_vec('{'0, mk_op7(0), 12'o301, 1, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
